// File: rtl/ps2_dir_decoder.sv
// PS/2 receive-only front end: synchronise, glitch-filter, frame and decode
// keyboard bytes into a snake direction plus start pulses.
module ps2_dir_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       MCLK,
    input  logic       RST_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] SCAN_CODE,
    output logic       CODE_VALID,
    output logic       FRAME_ERR,
    output logic [1:0] DIR,
    output logic       DIR_VALID,
    output logic       START
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic          fall_en;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [7:0]    scan_q;
    logic          code_valid_q, frame_err_q;

    logic          e0_q, f0_q;
    logic [1:0]    dir_q;
    logic          dir_valid_q, start_q;
    logic          req_vld, is_space, accept;
    logic [1:0]    req_dir;

    // The filtered clock only follows the synchronised clock after it has held
    // the opposite level for FILTER_LEN consecutive samples.
    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
        end else begin
            clk_s1_q <= PS2_CLK;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= PS2_DATA;
            dat_s2_q <= dat_s1_q;
            if (clk_s2_q != filt_q) begin
                if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                    filt_q <= clk_s2_q;
                    fcnt_q <= '0;
                end else begin
                    fcnt_q <= fcnt_q + 1'b1;
                end
            end else begin
                fcnt_q <= '0;
            end
        end
    end

    assign fall_en = filt_q && !clk_s2_q && (fcnt_q == FW'(FILTER_LEN - 1));

    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES));

    always_comb begin
        tmo_d = tmo_q;
        if (fall_en)
            tmo_d = '0;
        else if (!tmo_hit)
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge MCLK) begin
        if (!RST_N)
            tmo_q <= '0;
        else
            tmo_q <= tmo_d;
    end

    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            scan_q       <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (fall_en) begin
                case (state_q)
                    S_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7)
                            state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        if (dat_s2_q && ((^shift_q) ^ par_q)) begin
                            scan_q       <= shift_q;
                            code_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (tmo_hit && state_q != S_IDLE) begin
                state_q     <= S_IDLE;
                frame_err_q <= 1'b1;
            end
        end
    end

    // Arrow codes need the E0 prefix; letter keys are taken with or without it.
    always_comb begin
        req_vld  = 1'b0;
        req_dir  = dir_q;
        is_space = 1'b0;
        case (scan_q)
            8'h75: begin req_vld = e0_q; req_dir = DIR_UP;    end
            8'h72: begin req_vld = e0_q; req_dir = DIR_DOWN;  end
            8'h6B: begin req_vld = e0_q; req_dir = DIR_LEFT;  end
            8'h74: begin req_vld = e0_q; req_dir = DIR_RIGHT; end
            8'h1D: begin req_vld = 1'b1; req_dir = DIR_UP;    end
            8'h1B: begin req_vld = 1'b1; req_dir = DIR_DOWN;  end
            8'h1C: begin req_vld = 1'b1; req_dir = DIR_LEFT;  end
            8'h23: begin req_vld = 1'b1; req_dir = DIR_RIGHT; end
            8'h29: is_space = !e0_q;
            default: ;
        endcase
    end

    assign accept = req_vld && (req_dir != dir_q) && ((req_dir ^ dir_q) != 2'b10);

    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            e0_q        <= 1'b0;
            f0_q        <= 1'b0;
            dir_q       <= DIR_RIGHT;
            dir_valid_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            dir_valid_q <= 1'b0;
            start_q     <= 1'b0;
            if (frame_err_q) begin
                e0_q <= 1'b0;
                f0_q <= 1'b0;
            end else if (code_valid_q) begin
                if (scan_q == 8'hE0) begin
                    e0_q <= 1'b1;
                end else if (scan_q == 8'hF0) begin
                    f0_q <= 1'b1;
                end else begin
                    if (!f0_q) begin
                        if (accept) begin
                            dir_q       <= req_dir;
                            dir_valid_q <= 1'b1;
                        end
                        start_q <= is_space;
                    end
                    e0_q <= 1'b0;
                    f0_q <= 1'b0;
                end
            end
        end
    end

    assign SCAN_CODE  = scan_q;
    assign CODE_VALID = code_valid_q;
    assign FRAME_ERR  = frame_err_q;
    assign DIR        = dir_q;
    assign DIR_VALID  = dir_valid_q;
    assign START      = start_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Directed bench for ps2_dir_decoder: drives PS/2 frames and checks decoded
// codes, direction changes, start pulses and frame errors.
module tb_ps2_dir_decoder;

    localparam int HALF = 20;

    logic       MCLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic [7:0] SCAN_CODE;
    logic       CODE_VALID, FRAME_ERR, DIR_VALID, START;
    logic [1:0] DIR;

    ps2_dir_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(200)) dut (
        .MCLK(MCLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .SCAN_CODE(SCAN_CODE), .CODE_VALID(CODE_VALID), .FRAME_ERR(FRAME_ERR),
        .DIR(DIR), .DIR_VALID(DIR_VALID), .START(START)
    );

    always #5 MCLK = ~MCLK;

    int cyc = 0;
    int n_cv = 0, n_fe = 0, n_dv = 0, n_st = 0;
    int last_cv = 0, last_dv = 0, last_fe = 0;
    int b_cv, b_fe, b_dv, b_st;
    int last_fall = 0;
    int n_chk = 0, n_pass = 0;

    // Pulse counters count high cycles, so a stretched pulse shows as extra.
    always @(negedge MCLK) begin
        cyc <= cyc + 1;
        if (CODE_VALID) begin n_cv <= n_cv + 1; last_cv <= cyc; end
        if (FRAME_ERR)  begin n_fe <= n_fe + 1; last_fe <= cyc; end
        if (DIR_VALID)  begin n_dv <= n_dv + 1; last_dv <= cyc; end
        if (START)      n_st <= n_st + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic snap();
        b_cv = n_cv; b_fe = n_fe; b_dv = n_dv; b_st = n_st;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par, input bit stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            PS2_DATA = f[i];
            if (glitch && i == 3) begin
                tick(5); PS2_CLK = 1'b0; tick(2); PS2_CLK = 1'b1; tick(HALF - 7);
            end else begin
                tick(HALF);
            end
            PS2_CLK = 1'b0;
            last_fall = cyc;
            tick(HALF);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
        tick(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame(b, 1'b0, 1'b1), 11, 1'b0);
        tick(40);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick(3);
        RST_N = 1'b1;
    endtask

    initial begin
        int waited;
        tick(1);
        do_reset();
        tick(100);
        chk("reset_dir", DIR, 1);
        chk("reset_scan", SCAN_CODE, 0);
        chk("reset_cv", n_cv, 0);
        chk("reset_fe", n_fe, 0);
        chk("reset_dv", n_dv, 0);
        chk("reset_st", n_st, 0);

        snap(); send_byte(8'h1D);
        chk("w_scan", SCAN_CODE, 8'h1D);
        chk("w_cv", n_cv - b_cv, 1);
        chk("w_dv", n_dv - b_dv, 1);
        chk("w_dir", DIR, 0);
        chk("w_dv_lat", last_dv - last_cv, 1);

        snap(); send_byte(8'hE0); send_byte(8'h74);
        chk("right_cv", n_cv - b_cv, 2);
        chk("right_dv", n_dv - b_dv, 1);
        chk("right_dir", DIR, 1);

        snap(); send_byte(8'hE0); send_byte(8'h6B);
        chk("rev_dv", n_dv - b_dv, 0);
        chk("rev_dir", DIR, 1);
        chk("rev_scan", SCAN_CODE, 8'h6B);

        snap(); send_byte(8'h75);
        chk("keypad_dv", n_dv - b_dv, 0);
        chk("keypad_dir", DIR, 1);

        snap(); send_byte(8'hE0); send_byte(8'h72);
        chk("down_dv", n_dv - b_dv, 1);
        chk("down_dir", DIR, 2);

        snap(); send_byte(8'hE0); send_byte(8'h72);
        chk("repeat_dv", n_dv - b_dv, 0);

        snap(); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        chk("break_cv", n_cv - b_cv, 3);
        chk("break_scan", SCAN_CODE, 8'h6B);
        chk("break_dv", n_dv - b_dv, 0);
        chk("break_dir", DIR, 2);

        snap(); send_bits(frame(8'h23, 1'b1, 1'b1), 11, 1'b0); tick(40);
        chk("par_fe", n_fe - b_fe, 1);
        chk("par_cv", n_cv - b_cv, 0);
        chk("par_scan", SCAN_CODE, 8'h6B);
        chk("par_dir", DIR, 2);

        snap(); send_bits(frame(8'h1D, 1'b0, 1'b0), 11, 1'b0); tick(40);
        chk("stop_fe", n_fe - b_fe, 1);
        chk("stop_cv", n_cv - b_cv, 0);

        snap(); send_bits(11'h7FF, 1, 1'b0); tick(40);
        chk("startbit_fe", n_fe - b_fe, 1);

        snap(); send_bits(frame(8'h29, 1'b0, 1'b1), 5, 1'b0);
        waited = 0;
        while (n_fe == b_fe && waited < 400) begin tick(1); waited++; end
        chk("tmo_seen", n_fe - b_fe, 1);
        chk("tmo_delay_ok", int'((last_fe - last_fall) >= 200 && (last_fe - last_fall) <= 215), 1);
        chk("tmo_cv", n_cv - b_cv, 0);
        tick(20);

        snap(); send_byte(8'h29);
        chk("space_st", n_st - b_st, 1);
        chk("space_scan", SCAN_CODE, 8'h29);
        chk("space_fe", n_fe - b_fe, 0);
        chk("space_dir", DIR, 2);

        snap();
        PS2_CLK = 1'b0; tick(2); PS2_CLK = 1'b1; tick(20);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 1'b1); tick(40);
        chk("glitch_fe", n_fe - b_fe, 0);
        chk("glitch_cv", n_cv - b_cv, 1);
        chk("glitch_scan", SCAN_CODE, 8'h1C);
        chk("glitch_dir", DIR, 3);
        chk("glitch_dv", n_dv - b_dv, 1);

        send_bits(frame(8'h23, 1'b0, 1'b1), 5, 1'b0);
        do_reset();
        tick(10);
        snap(); send_byte(8'h1C);
        chk("rstmid_scan", SCAN_CODE, 8'h1C);
        chk("rstmid_fe", n_fe - b_fe, 0);
        chk("rstmid_cv", n_cv - b_cv, 1);
        chk("rstmid_dv", n_dv - b_dv, 0);
        chk("rstmid_dir", DIR, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
